// File: rtl/sram_mem_responder.sv
// MEM-stage data-memory responder: 32-bit requests served as two 16-bit SRAM accesses.
// Optional range/alignment checking is enabled with `define MEM_RANGE_CHECK_EN.
module sram_mem_responder #(
    parameter int ADDR_BASE   = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [31:0] address,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        ready,
    output logic        addr_err,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    input  logic [15:0] sram_dq_in,
    output logic        sram_dq_oe,
    output logic        sram_we_n,
    output logic        sram_oe_n
);
    localparam int CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

    generate
        if (WAIT_CYCLES < 1) begin : g_cfg_err
            $error("sram_mem_responder: WAIT_CYCLES must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_wr, w_wr_nxt;
    logic [31:0]   r_rd_data, w_rd_nxt;
    logic          r_addr_err, w_err_nxt;
    logic          w_req, w_bad, w_last, w_act, w_hi;
    logic [16:0]   w_word;

    assign w_req  = mem_r_en | mem_w_en;
    assign w_word = 17'((address - 32'(ADDR_BASE)) >> 2);
    assign w_last = (r_cnt == CW'(WAIT_CYCLES));
    assign w_hi   = (r_state == S_HI);
    assign w_act  = (r_state == S_LO) || w_hi;

`ifdef MEM_RANGE_CHECK_EN
    logic [31:0] w_off;
    assign w_off = address - 32'(ADDR_BASE);
    assign w_bad = (address < 32'(ADDR_BASE))
                 | (w_off >= 32'h0008_0000)
                 | (address[1:0] != 2'b00);
`else
    assign w_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_wr       <= 1'b0;
            r_rd_data  <= '0;
            r_addr_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_wr       <= w_wr_nxt;
            r_rd_data  <= w_rd_nxt;
            r_addr_err <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_wr_nxt    = r_wr;
        w_rd_nxt    = r_rd_data;
        w_err_nxt   = r_addr_err;
        unique case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_wr_nxt  = mem_w_en;
                    w_cnt_nxt = '0;
                    // Invalid requests skip the SRAM entirely
                    if (w_bad) begin
                        w_state_nxt = S_DONE;
                        w_err_nxt   = 1'b1;
                        if (!mem_w_en) w_rd_nxt = '0;
                    end else begin
                        w_state_nxt = S_LO;
                    end
                end
            end
            S_LO: begin
                if (w_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_HI;
                    if (!r_wr) w_rd_nxt[15:0] = sram_dq_in;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_HI: begin
                if (w_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_DONE;
                    if (!r_wr) w_rd_nxt[31:16] = sram_dq_in;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign ready       = (r_state == S_IDLE) ? ~w_req : (r_state == S_DONE);
    assign sram_addr   = w_act ? {w_word, w_hi} : '0;
    assign sram_dq_oe  = w_act & r_wr;
    assign sram_dq_out = (w_act & r_wr) ? (w_hi ? wr_data[31:16] : wr_data[15:0]) : '0;
    // First cycle of each phase is address setup before the write strobe
    assign sram_we_n   = ~(w_act & r_wr & (r_cnt != '0));
    assign sram_oe_n   = ~(w_act & ~r_wr);
    assign rd_data     = r_rd_data;
    assign addr_err    = r_addr_err;

endmodule

// File: tb/tb_sram_mem_responder.sv
// Directed bench for sram_mem_responder with a behavioural async SRAM model.
// Define MEM_RANGE_CHECK_EN for both files to exercise the range-check path.
module tb_sram_mem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_r_en = 1'b0;
    logic        mem_w_en = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data;
    logic        ready;
    logic        addr_err;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;
    logic        sram_oe_n;

    always #5 clk = ~clk;

    sram_mem_responder #(.ADDR_BASE(1024), .WAIT_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .address(address), .wr_data(wr_data),
        .rd_data(rd_data), .ready(ready), .addr_err(addr_err),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
        .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe),
        .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
    );

    logic [15:0] sram [1024];
    assign sram_dq_in = sram_oe_n ? 16'h0000 : sram[sram_addr[9:0]];
    always @(posedge clk)
        if (!sram_we_n && sram_dq_oe) sram[sram_addr[9:0]] <= sram_dq_out;

    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] exp_q [$];
    logic [31:0] ref_mem [int];
    int          lo_cnt, we_cnt, oe_cnt;
    logic [17:0] a_first, a_last;
    logic        got_a, rd_changed, timeout;
    logic [31:0] rd_before;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic sample();
        if (!ready) lo_cnt++;
        if (!sram_we_n) we_cnt++;
        if (!sram_oe_n) oe_cnt++;
        if (!sram_oe_n || sram_dq_oe) begin
            if (!got_a) a_first = sram_addr;
            got_a  = 1'b1;
            a_last = sram_addr;
        end
        if (rd_data !== rd_before) rd_changed = 1'b1;
    endtask

    task automatic req(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d);
        mem_r_en = rd; mem_w_en = wr; address = a; wr_data = d;
        lo_cnt = 0; we_cnt = 0; oe_cnt = 0; got_a = 1'b0;
        a_first = '0; a_last = '0;
        rd_before = rd_data; rd_changed = 1'b0; timeout = 1'b1;
        if (wr) ref_mem[a] = d;
        else exp_q.push_back(ref_mem.exists(a) ? ref_mem[a] : 32'h0);
        #1;
        sample();
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (ready) begin
                timeout = 1'b0;
                break;
            end
            sample();
        end
        chk("timeout", {31'd0, timeout}, 32'd0);
        if (wr) begin
            if (rd_data !== rd_before) rd_changed = 1'b1;
        end else begin
            chk("rd_data_done", rd_data, exp_q.pop_front());
        end
    endtask

    task automatic next();
        @(posedge clk); #1;
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) sram[i] = 16'hA5A5;
        #1;
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_addr_err", {31'd0, addr_err}, 32'd0);
        chk("rst_sram_addr", {14'd0, sram_addr}, 32'd0);
        chk("rst_strobes", {29'd0, sram_we_n, sram_oe_n, sram_dq_oe}, 32'b110);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        req(1'b0, 1'b1, 32'd1024, 32'hDEAD_BEEF);
        chk("wr_ready_low", lo_cnt, 5);
        chk("wr_we_cycles", we_cnt, 2);
        chk("wr_oe_cycles", oe_cnt, 0);
        chk("wr_done_ready", {31'd0, ready}, 32'd1);
        chk("sram_hw0", {16'd0, sram[0]}, 32'h0000_BEEF);
        chk("sram_hw1", {16'd0, sram[1]}, 32'h0000_DEAD);
        next();

        req(1'b1, 1'b0, 32'd1024, 32'h0);
        chk("rd_oe_cycles", oe_cnt, 4);
        chk("rd_we_cycles", we_cnt, 0);
        chk("rd_ready_low", lo_cnt, 5);
        next();

        req(1'b0, 1'b1, 32'd1028, 32'h1234_5678);
        chk("rd_hold_wr", {31'd0, rd_changed}, 32'd0);
        chk("rd_after_wr", rd_data, 32'hDEAD_BEEF);
        next();
        req(1'b1, 1'b0, 32'd1028, 32'h0);
        chk("rd_addr_lo", {14'd0, a_first}, 32'd2);
        chk("rd_addr_hi", {14'd0, a_last}, 32'd3);
        next();

        #2 rst = 1'b0;
        #1;
        chk("midrst_ready", {31'd0, ready}, 32'd1);
        chk("midrst_rd_data", rd_data, 32'h0);
        chk("midrst_strobes", {29'd0, sram_we_n, sram_oe_n, sram_dq_oe}, 32'b110);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;

        mem_w_en = 1'b1; address = 32'd1032; wr_data = 32'hCAFE_F00D;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("hi_phase_addr", {14'd0, sram_addr}, 32'd5);
        rst = 1'b0;
        mem_w_en = 1'b0;
        #1;
        chk("abort_ready", {31'd0, ready}, 32'd1);
        chk("abort_strobes", {30'd0, sram_we_n, sram_dq_oe}, 32'b10);
        @(posedge clk); #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_idle_ready", {31'd0, ready}, 32'd1);
        chk("abort_hw4", {16'd0, sram[4]}, 32'h0000_F00D);
        chk("abort_hw5", {16'd0, sram[5]}, 32'h0000_A5A5);

        req(1'b1, 1'b0, 32'd1024, 32'h0);
        next();

`ifdef MEM_RANGE_CHECK_EN
        req(1'b1, 1'b0, 32'h0000_0100, 32'h0);
        chk("bad_ready_low", lo_cnt, 1);
        chk("bad_no_strobes", oe_cnt + we_cnt, 0);
        chk("bad_addr_err", {31'd0, addr_err}, 32'd1);
        next();
        req(1'b1, 1'b0, 32'd1028, 32'h0);
        chk("err_sticky", {31'd0, addr_err}, 32'd1);
        next();
`else
        req(1'b1, 1'b0, 32'd1028, 32'h0);
        chk("no_addr_err", {31'd0, addr_err}, 32'd0);
        next();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
